// File: rtl/ising_run_seq_if.sv
// Result-FIFO drain port of the Ising run sequencer.
// The master side presents the FIFO head; the slave side pops it.
interface ising_run_seq_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic [CW-1:0] res_count;

    modport master (output res_valid, res_data, res_count, input res_ready);
    modport slave  (input res_valid, res_data, res_count, output res_ready);
endinterface

// File: rtl/ising_run_seq.sv
// Repeats reset/anneal runs on the Ising core and queues each run's phase result.
// Optional minimum-phase tracking is enabled by defining ISING_RUN_MIN_TRACK_EN.
module ising_run_seq #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_runs,
    input  logic [15:0] reset_cycles,
    input  logic [31:0] run_cycles,
    input  logic [31:0] cfg_counter_max,
    input  logic [31:0] cfg_counter_cutoff,
    input  logic [31:0] phase,
    output logic        ising_rstn,
    output logic [31:0] counter_max,
    output logic [31:0] counter_cutoff,
    output logic        busy,
    output logic        done,
    output logic [15:0] runs_done,
    output logic        overflow,
    ising_run_seq_if.master res_if
`ifdef ISING_RUN_MIN_TRACK_EN
   ,output logic [31:0] min_phase,
    output logic [15:0] min_idx
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {IDLE, RESET, RUN, SETTLE, CAPTURE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] num_runs_q, reset_cycles_q;
    logic [31:0] run_cycles_q;
    logic        accept, capture, seq_done, last_run;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          res_valid_q, full, pop, push_ok;

    assign last_run = (runs_done + 16'd1) == num_runs_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counters load length-1 on entry, so a zero length behaves as one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        capture  = 1'b0;
        seq_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_runs == '0) begin
                        seq_done = 1'b1;
                    end else begin
                        state_d = RESET;
                        cnt_d   = (reset_cycles == '0) ? '0 : {16'd0, reset_cycles} - 32'd1;
                    end
                end
            end
            RESET: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                    cnt_d   = (run_cycles_q == '0) ? '0 : run_cycles_q - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = 32'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - 32'd1;
            end
            CAPTURE: begin
                capture = 1'b1;
                if (last_run) begin
                    state_d  = IDLE;
                    seq_done = !abort;
                end else begin
                    state_d = RESET;
                    cnt_d   = (reset_cycles_q == '0) ? '0 : {16'd0, reset_cycles_q} - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any transition but never suppresses a capture already due.
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ising_rstn     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            runs_done      <= '0;
            num_runs_q     <= '0;
            reset_cycles_q <= '0;
            run_cycles_q   <= '0;
            counter_max    <= '0;
            counter_cutoff <= '0;
        end else begin
            ising_rstn <= state_d inside {RUN, SETTLE, CAPTURE};
            busy       <= state_d != IDLE;
            done       <= seq_done;
            if (accept) begin
                num_runs_q     <= num_runs;
                reset_cycles_q <= reset_cycles;
                run_cycles_q   <= run_cycles;
                counter_max    <= cfg_counter_max;
                counter_cutoff <= cfg_counter_cutoff;
                runs_done      <= '0;
            end else if (capture) begin
                runs_done <= runs_done + 16'd1;
            end
        end
    end

    assign full    = count == CW'(FIFO_DEPTH);
    assign pop     = res_valid_q && res_if.res_ready;
    assign push_ok = capture && (!full || pop);

    always_comb begin
        count_d = count;
        unique case ({push_ok, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            res_valid_q <= 1'b0;
            overflow    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= phase;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count       <= count_d;
            res_valid_q <= count_d != '0;
            if (accept)                        overflow <= 1'b0;
            else if (capture && full && !pop)  overflow <= 1'b1;
        end
    end

    assign res_if.res_valid = res_valid_q;
    assign res_if.res_data  = mem[rd_ptr];
    assign res_if.res_count = count;

`ifdef ISING_RUN_MIN_TRACK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            min_phase <= '1;
            min_idx   <= '0;
        end else if (accept) begin
            min_phase <= '1;
            min_idx   <= '0;
        end else if (capture && phase < min_phase) begin
            min_phase <= phase;
            min_idx   <= runs_done;
        end
    end
`endif

endmodule

// File: doc/ising_run_seq.md
# ising_run_seq

Run sequencer sitting directly upstream of the Ising top level. It drives the machine's `ising_rstn`, `counter_max` and `counter_cutoff`, repeats a programmed number of reset/anneal runs, and captures the sampler's 32-bit `phase` result at the end of each run. Captured results go into a small result FIFO that software drains over the existing register interface.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: result FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 2: cycles between end of run window and capture, covering sampler output latency; ≥1.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle start pulse; ignored unless IDLE.
- `abort` in 1: stop the sequence; ignored in IDLE.
- `num_runs` in 16: runs per sequence; latched on `start`.
- `reset_cycles` in 16: Ising reset hold per run; latched; 0 treated as 1.
- `run_cycles` in 32: anneal window per run; latched; 0 treated as 1.
- `cfg_counter_max` in 32: latched on `start`.
- `cfg_counter_cutoff` in 32: latched on `start`.
- `phase` in 32: sampler result.
- `ising_rstn` out 1: reset to oscillator core and sampler.
- `counter_max` out 32: latched copy.
- `counter_cutoff` out 32: latched copy.
- `busy` out 1: high when not IDLE.
- `done` out 1: one-cycle pulse when a sequence completes normally.
- `runs_done` out 16: runs captured in the current or last sequence.
- `res_valid` out 1: FIFO non-empty.
- `res_ready` in 1: pop handshake.
- `res_data` out 32: FIFO head.
- `res_count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `overflow` out 1: sticky; a capture was dropped because the FIFO was full.
- `min_phase` out 32, `min_idx` out 16: present only with `ISING_RUN_MIN_TRACK_EN`.

## Operation
- FSM states: IDLE, RESET, RUN, SETTLE, CAPTURE.
- **IDLE**
  - `ising_rstn`=0.
  - On `start`: latch all config, clear `runs_done` and `overflow`, then go to RESET.
  - If `num_runs`=0: stay in IDLE and pulse `done` next cycle.
- **RESET**: `ising_rstn`=0 for max(`reset_cycles`,1) cycles, then go to RUN.
- **RUN**: `ising_rstn`=1 for max(`run_cycles`,1) cycles, then go to SETTLE.
- **SETTLE**: `ising_rstn`=1 for `SETTLE_CYCLES` cycles, then go to CAPTURE.
- **CAPTURE** (1 cycle, `ising_rstn`=1)
  - Push `phase` to the FIFO and increment `runs_done`.
  - If `runs_done`+1 equals `num_runs`: go to IDLE and pulse `done`. Otherwise go to RESET.
- **Abort**
  - From any non-IDLE state, go to IDLE next cycle.
  - No capture, no `done` pulse.
  - FIFO contents, `runs_done` and `overflow` are retained.
  - Abort coinciding with CAPTURE: the capture still occurs, then the FSM goes to IDLE without `done`.
- **FIFO**
  - Pop occurs when `res_valid`&&`res_ready`.
  - Push when full: the value is dropped and `overflow` set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Pop when empty: no effect.
- `start` while busy is ignored; the latched config is unchanged.

## Timing
- Reset values:
  - `ising_rstn`=0; `counter_max`, `counter_cutoff`=0.
  - `busy`, `done`, `res_valid`, `overflow`=0; `runs_done`, `res_count`=0; `res_data`=0.
  - `min_phase`=32'hFFFFFFFF, `min_idx`=0.
- Let `start` be sampled at cycle 0, R=max(`reset_cycles`,1), T=max(`run_cycles`,1), S=`SETTLE_CYCLES`.
  - `busy` is high from cycle 1.
  - `ising_rstn` is low in cycles 1..R and high in cycles R+1..R+T+S+1.
  - CAPTURE is at cycle R+T+S+1.
- Period per run is R+T+S+1 cycles.
- `res_valid` and `res_count` update the cycle after CAPTURE.
- `done` is high the cycle after the final CAPTURE; `busy` is low in that same cycle.
- All outputs are registered. `res_data` shows the head with zero added latency.

## Configuration
- `ISING_RUN_MIN_TRACK_EN` defined:
  - On each CAPTURE, if `phase` < `min_phase` (unsigned), `min_phase`←`phase` and `min_idx`←`runs_done`. Strict less-than, so the first run holds ties.
  - Both outputs reset on `start`.
- Not defined: `min_phase` and `min_idx` ports and logic are absent.

## Test plan
- `num_runs`=3, `reset_cycles`=4, `run_cycles`=10, SETTLE=2, `phase` ramp 5,3,7 -> `ising_rstn` low 4 and high 13 per run, 3 FIFO entries 5,3,7, single `done` at cycle 52, `runs_done`=3.
- `num_runs`=0 -> `done` pulse at cycle 1, `busy` never high, FIFO empty.
- `num_runs`=10 with `res_ready`=0, depth 8 -> `res_count`=8, `overflow`=1, first 8 values retained in order.
- `abort` during RUN of run 2 of 4 -> IDLE next cycle, `ising_rstn`=0, `runs_done`=1, no `done`; a new `start` clears `overflow` and `runs_done`.
- FIFO full with `res_ready`=1 held during a CAPTURE -> count stays 8, `overflow`=0, order preserved across pointer wrap.
- With `ISING_RUN_MIN_TRACK_EN`, phases 9,4,4,6 -> `min_phase`=4, `min_idx`=1.
